// File: rtl/vc_allocator.sv
// Output-port VC allocator: round-robin requester pick, lowest free output VC, per-VC credit counters.
// Optional VC_ALLOC_CREDIT_GATE_EN: output VCs with zero credit are not eligible for allocation.
module vc_allocator #(
    parameter int NUM_REQ      = 8,
    parameter int NUM_OVC      = 4,
    parameter int OVC_IDX_W    = 2,
    parameter int CREDIT_WIDTH = 3,
    parameter int MAX_CREDIT   = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              req,
    output logic [NUM_REQ-1:0]              grant,
    output logic [OVC_IDX_W-1:0]            grant_ovc,
    input  logic [NUM_OVC-1:0]              release_ovc,
    input  logic                            flit_sent,
    input  logic [OVC_IDX_W-1:0]            flit_sent_ovc,
    input  logic [NUM_OVC-1:0]              credit_in,
    output logic [NUM_OVC*CREDIT_WIDTH-1:0] credit,
    output logic [NUM_OVC-1:0]              ovc_busy
);

    localparam int REQ_IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [CREDIT_WIDTH-1:0] CRED_MAX = CREDIT_WIDTH'(MAX_CREDIT);

    logic [REQ_IDX_W-1:0] rr_ptr;
    logic [NUM_REQ-1:0]   req_elig;
    logic [NUM_OVC-1:0]   ovc_elig;
    logic [NUM_OVC-1:0]   cred_nz;
    logic                 win_found;
    logic [REQ_IDX_W-1:0] win_idx;
    logic                 ovc_found;
    logic [OVC_IDX_W-1:0] ovc_idx;
    logic                 alloc;
    int                   j;

    // A requester is masked while its grant is on display to avoid a double grant.
    assign req_elig = req & ~grant;

`ifdef VC_ALLOC_CREDIT_GATE_EN
    assign ovc_elig = ~ovc_busy & cred_nz;
`else
    assign ovc_elig = ~ovc_busy;
`endif

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        j         = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(rr_ptr) + i) % NUM_REQ;
            if (!win_found && req_elig[j]) begin
                win_found = 1'b1;
                win_idx   = REQ_IDX_W'(j);
            end
        end
    end

    always_comb begin
        ovc_found = 1'b0;
        ovc_idx   = '0;
        for (int k = 0; k < NUM_OVC; k++) begin
            if (!ovc_found && ovc_elig[k]) begin
                ovc_found = 1'b1;
                ovc_idx   = OVC_IDX_W'(k);
            end
        end
    end

    assign alloc = win_found && ovc_found;

    always_ff @(posedge clk) begin
        if (rst) begin
            grant     <= '0;
            grant_ovc <= '0;
            ovc_busy  <= '0;
            rr_ptr    <= '0;
        end else begin
            // Release uses the pre-release busy value for eligibility, so a
            // released VC can never collide with this cycle's allocation.
            ovc_busy <= ovc_busy & ~release_ovc;
            if (alloc) begin
                grant             <= NUM_REQ'(1) << win_idx;
                grant_ovc         <= ovc_idx;
                ovc_busy[ovc_idx] <= 1'b1;
                rr_ptr            <= (int'(win_idx) == NUM_REQ - 1)
                                     ? '0 : win_idx + 1'b1;
            end else begin
                grant     <= '0;
                grant_ovc <= '0;
            end
        end
    end

    for (genvar k = 0; k < NUM_OVC; k++) begin : g_cred
        logic [CREDIT_WIDTH-1:0] cnt;
        logic                    dec;
        logic                    inc;

        assign dec = flit_sent && (flit_sent_ovc == OVC_IDX_W'(k));
        assign inc = credit_in[k];

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt <= CRED_MAX;
            end else if (dec && !inc) begin
                if (cnt != '0)
                    cnt <= cnt - 1'b1;
            end else if (inc && !dec) begin
                if (cnt != CRED_MAX)
                    cnt <= cnt + 1'b1;
            end
        end

        assign credit[k*CREDIT_WIDTH +: CREDIT_WIDTH] = cnt;
        assign cred_nz[k] = (cnt != '0);
    end

endmodule

// File: tb/tb_vc_allocator.sv
// Directed bench for vc_allocator: reset, round-robin, exhaustion, release, credits.
module tb_vc_allocator;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  req;
    logic [7:0]  grant;
    logic [1:0]  grant_ovc;
    logic [3:0]  release_ovc;
    logic        flit_sent;
    logic [1:0]  flit_sent_ovc;
    logic [3:0]  credit_in;
    logic [11:0] credit;
    logic [3:0]  ovc_busy;

    int n_chk  = 0;
    int n_pass = 0;

    vc_allocator dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .grant        (grant),
        .grant_ovc    (grant_ovc),
        .release_ovc  (release_ovc),
        .flit_sent    (flit_sent),
        .flit_sent_ovc(flit_sent_ovc),
        .credit_in    (credit_in),
        .credit       (credit),
        .ovc_busy     (ovc_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] cr(input int k);
        logic [11:0] c;
        c = credit;
        return c[k*3 +: 3];
    endfunction

    logic [1:0] exp_gate_ovc;
    int         cr_exp[6];

    initial begin
`ifdef VC_ALLOC_CREDIT_GATE_EN
        exp_gate_ovc = 2'd1;
`else
        exp_gate_ovc = 2'd0;
`endif
        cr_exp = '{1, 2, 3, 4, 4, 4};
        rst = 1'b1; req = '0; release_ovc = '0;
        flit_sent = 1'b0; flit_sent_ovc = '0; credit_in = '0;
        tick(); tick();
        rst = 1'b0;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_busy", 32'(ovc_busy), 32'h0);
        check("rst_credit", 32'(credit), 32'h924);

        req = 8'b0000_0101;
        tick();
        check("rr_g0", 32'(grant), 32'h01);
        check("rr_o0", 32'(grant_ovc), 32'd0);
        req = 8'b0000_0100;
        tick();
        check("rr_g1", 32'(grant), 32'h04);
        check("rr_o1", 32'(grant_ovc), 32'd1);
        check("rr_busy", 32'(ovc_busy), 32'h3);
        req = '0;
        tick();
        check("rr_idle", 32'(grant), 32'h0);

        req = 8'b0000_0011;
        tick();
        check("fill_g0", 32'(grant), 32'h01);
        check("fill_o0", 32'(grant_ovc), 32'd2);
        req = 8'b0000_0010;
        tick();
        check("fill_g1", 32'(grant), 32'h02);
        check("fill_o1", 32'(grant_ovc), 32'd3);
        check("fill_busy", 32'(ovc_busy), 32'hf);
        req = 8'b0000_1000;
        tick();
        check("exh_g0", 32'(grant), 32'h0);
        tick();
        check("exh_g1", 32'(grant), 32'h0);
        release_ovc = 4'b0100;
        tick();
        release_ovc = '0;
        check("rel_busy", 32'(ovc_busy), 32'hb);
        check("rel_nogrant", 32'(grant), 32'h0);
        tick();
        check("rel_g", 32'(grant), 32'h08);
        check("rel_o", 32'(grant_ovc), 32'd2);
        req = '0;

        flit_sent = 1'b1; flit_sent_ovc = 2'd1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("cr_dec%0d", i), 32'(cr(1)), 32'((i < 3) ? 3 - i : 0));
        end
        check("cr_other", 32'(cr(0)), 32'd4);
        flit_sent = 1'b0; credit_in = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("cr_inc%0d", i), 32'(cr(1)), 32'(cr_exp[i]));
        end
        credit_in = '0; flit_sent = 1'b1;
        tick();
        check("cr_pre", 32'(cr(1)), 32'd3);
        credit_in = 4'b0010;
        tick();
        check("cr_both", 32'(cr(1)), 32'd3);
        credit_in = '0; flit_sent = 1'b0;

        release_ovc = 4'b1110;
        tick();
        check("same_busy0", 32'(ovc_busy), 32'h1);
        release_ovc = 4'b0001; req = 8'h20;
        tick();
        release_ovc = '0; req = '0;
        check("same_g", 32'(grant), 32'h20);
        check("same_o", 32'(grant_ovc), 32'd1);
        check("same_busy1", 32'(ovc_busy), 32'h2);

        release_ovc = 4'b1111;
        flit_sent = 1'b1; flit_sent_ovc = 2'd0;
        tick();
        release_ovc = '0;
        tick(); tick(); tick();
        flit_sent = 1'b0;
        check("gate_cr0", 32'(cr(0)), 32'd0);
        check("gate_busy", 32'(ovc_busy), 32'h0);
        req = 8'h01;
        tick();
        req = '0;
        check("gate_g", 32'(grant), 32'h01);
        check("gate_o", 32'(grant_ovc), 32'(exp_gate_ovc));

        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_grant", 32'(grant), 32'h0);
        check("mrst_busy", 32'(ovc_busy), 32'h0);
        check("mrst_credit", 32'(credit), 32'h924);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/vc_allocator.md
# vc_allocator

Output-port virtual-channel allocator for the dynamic router. It shares the output VCs of one output port among the input VCs whose head flits have been routed to that port. Free output VCs go to requesters in round-robin order, and each output VC stays held until its tail flit has left. The block also keeps the downstream credit count for every output VC, which the input VCs compare against before forwarding flits.

## Interface
Parameters:
- NUM_REQ, 8, number of requesting input VCs
- NUM_OVC, 4, number of output VCs on this port
- OVC_IDX_W, 2, width of an output-VC index (log2 NUM_OVC)
- CREDIT_WIDTH, 3, width of one credit counter
- MAX_CREDIT, 4, downstream buffer depth per output VC; credit reset value

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  req[i]=1: input VC i holds a head flit routed to this port and needs an output VC
- grant  out  NUM_REQ  one-hot, one-cycle grant pulse
- grant_ovc  out  OVC_IDX_W  output VC assigned with the current grant; valid only while grant≠0
- release  in  NUM_OVC  release[k]=1: tail flit of the packet holding output VC k has left
- flit_sent  in  1  one flit forwarded downstream this cycle
- flit_sent_ovc  in  OVC_IDX_W  output VC of that flit
- credit_in  in  NUM_OVC  credit_in[k]=1: downstream freed one slot of output VC k
- credit  out  NUM_OVC*CREDIT_WIDTH  credit count of output VC k in bits [k*CREDIT_WIDTH +: CREDIT_WIDTH]
- ovc_busy  out  NUM_OVC  ovc_busy[k]=1: output VC k is allocated

## Operation
- Reset values:
  - grant=0, grant_ovc=0, ovc_busy=0
  - every credit field=MAX_CREDIT
  - round-robin pointer rr_ptr=0
- Eligible requester: req[i]=1 and grant[i]=0. A requester is masked in the cycle its grant is shown, so no double grant occurs.
- Eligible output VC: ovc_busy[k]=0, using the current register value.
- Allocation, at most one grant per cycle:
  - Winner: first eligible requester searching rr_ptr, rr_ptr+1, … mod NUM_REQ.
  - Output VC: lowest-index eligible output VC.
  - On the next edge: grant[winner]=1, grant_ovc=k, ovc_busy[k]=1, rr_ptr=(winner+1) mod NUM_REQ.
  - With no winner or no free output VC: grant=0, and rr_ptr and ovc_busy are unchanged.
- Requester obligation: drop req[i] in the cycle grant[i] is seen, and keep it low until its next head flit.
- Release:
  - release[k] clears ovc_busy[k] on the next edge.
  - A release of a non-busy output VC is ignored.
- Simultaneous release[k] with an allocation decision in the same cycle:
  - k is not eligible that cycle, because eligibility uses the pre-release busy value.
  - k becomes eligible the following cycle.
- Credit counter k, per cycle:
  - dec = flit_sent && flit_sent_ovc==k
  - inc = credit_in[k]
  - inc && dec: unchanged
  - dec only: minus 1, held at 0 (no underflow)
  - inc only: plus 1, held at MAX_CREDIT (no overflow)
- Credit counters run independently of busy state and are not cleared by release.

## Timing
- Allocation latency: req sampled at edge t; grant and grant_ovc visible after edge t; ovc_busy set at that same edge.
- Back-to-back grants to different requesters are possible every cycle while free output VCs exist.
- Release to re-allocation of the same output VC: minimum 2 edges.
- Credit update latency: 1 edge; the credit output is registered.
- rst asserted mid-operation: every register returns to its reset value on the next edge. Outstanding grants are lost; holders must re-request.

## Configuration
- VC_ALLOC_CREDIT_GATE_EN
  - Defined: an output VC is eligible only if ovc_busy[k]=0 and its credit ≥1, so packets are never bound to a starved output VC.
  - Undefined: eligibility depends on ovc_busy only; credit does not influence allocation.

## Test plan
- Reset: assert rst 2 cycles → grant=0, ovc_busy=4'b0000, all four credit fields=4.
- Round-robin, two requesters: req=8'b0000_0101 with each requester dropping req on its grant → grant=0x01, grant_ovc=0, then grant=0x04, grant_ovc=1; ovc_busy=4'b0011.
- Exhaustion and release: all four output VCs busy, req[3]=1 → grant stays 0. Pulse release=4'b0100 → ovc_busy=4'b1011 after 1 edge, then grant=0x08 with grant_ovc=2 on the next edge.
- Credit saturation: 5 consecutive flit_sent with flit_sent_ovc=1 → credit[1] goes 3,2,1,0,0. Then 6 credit_in[1] pulses → credit[1] rises and stays at 4. A simultaneous flit_sent to 1 with credit_in[1] leaves the value unchanged.
- Release same cycle as request: ovc_busy=4'b0001, release[0]=1 and req[5]=1 in the same cycle → grant=0x20 with grant_ovc=1; output VC 0 is not chosen.
- Macro defined: credit[0]=0, output VCs 0 and 1 free, req[0]=1 → grant_ovc=1. With the macro undefined, the same stimulus → grant_ovc=0.
